// File: rtl/mem_fill_arbiter_if.sv
// Cache-miss / store request bus and memory port shared by the fill arbiter.
// master: cache + memory side; slave: the arbiter.
interface mem_fill_arbiter_if #(
  parameter int unsigned BLOCK_WORDS = 8
);
  localparam int unsigned IDX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  logic             i_miss;
  logic [15:0]      i_miss_addr;
  logic             d_miss;
  logic [15:0]      d_miss_addr;
  logic             d_wr_req;
  logic [15:0]      d_wr_addr;
  logic [15:0]      d_wr_data;
  logic             mem_data_valid;
  logic [15:0]      mem_rdata;
  logic             mem_en;
  logic             mem_wr;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_wdata;
  logic             i_fill_we;
  logic             d_fill_we;
  logic [IDX_W-1:0] fill_idx;
  logic [15:0]      fill_data;
  logic             i_fill_done;
  logic             d_fill_done;
  logic             d_wr_done;
  logic             busy;

  modport master (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, d_wr_req, d_wr_addr, d_wr_data,
           mem_data_valid, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, i_fill_we, d_fill_we, fill_idx,
           fill_data, i_fill_done, d_fill_done, d_wr_done, busy
  );

  modport slave (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, d_wr_req, d_wr_addr, d_wr_data,
           mem_data_valid, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, i_fill_we, d_fill_we, fill_idx,
           fill_data, i_fill_done, d_fill_done, d_wr_done, busy
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Arbitrates I-miss, D-miss and write-through store traffic onto one pipelined
// memory port; block fills stream returned words into the owning cache array.
module mem_fill_arbiter #(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned BLOCK_WORDS = 8
) (
  input logic                clk,
  input logic                rst_n,
  mem_fill_arbiter_if.slave  bus
);
  localparam int unsigned IDX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int unsigned LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BLOCK_WORDS - 1);
  localparam logic [LAT_W-1:0] LAST_LAT  = LAT_W'(MEM_LATENCY - 1);
  localparam logic [15:0]      BASE_MASK = ~16'(2 * BLOCK_WORDS - 1);

  typedef enum logic [2:0] {DRAIN, IDLE, FILL_I, FILL_D, WRITE} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] iss_cnt, iss_cnt_nx;
  logic [IDX_W-1:0] ret_cnt, ret_cnt_nx;
  logic             iss_act, iss_act_nx;
  logic [LAT_W-1:0] lat_cnt, lat_cnt_nx;
  logic [15:0]      addr_q, addr_nx;
  logic [15:0]      wdata_q, wdata_nx;

  logic             en_c, wr_c, iwe_c, dwe_c, idone_c, ddone_c, wdone_c;
  logic [15:0]      maddr_c, mwdata_c, fdata_c;
  logic [IDX_W-1:0] idx_c;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= DRAIN;
      iss_cnt <= '0;
      ret_cnt <= '0;
      iss_act <= 1'b0;
      lat_cnt <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nx;
      iss_cnt <= iss_cnt_nx;
      ret_cnt <= ret_cnt_nx;
      iss_act <= iss_act_nx;
      lat_cnt <= lat_cnt_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
    end
  end

  // Next state and port outputs
  always_comb begin
    state_nx   = state;
    iss_cnt_nx = iss_cnt;
    ret_cnt_nx = ret_cnt;
    iss_act_nx = iss_act;
    lat_cnt_nx = lat_cnt;
    addr_nx    = addr_q;
    wdata_nx   = wdata_q;
    en_c       = 1'b0;
    wr_c       = 1'b0;
    maddr_c    = '0;
    mwdata_c   = '0;
    iwe_c      = 1'b0;
    dwe_c      = 1'b0;
    idx_c      = '0;
    fdata_c    = '0;
    idone_c    = 1'b0;
    ddone_c    = 1'b0;
    wdone_c    = 1'b0;

    case (state)
      DRAIN: begin
        if (lat_cnt == LAST_LAT) begin
          state_nx   = IDLE;
          lat_cnt_nx = '0;
        end else begin
          lat_cnt_nx = lat_cnt + 1'b1;
        end
      end

      IDLE: begin
        iss_cnt_nx = '0;
        ret_cnt_nx = '0;
        lat_cnt_nx = '0;
        iss_act_nx = 1'b0;
        if (bus.d_wr_req) begin
          state_nx = WRITE;
          addr_nx  = bus.d_wr_addr;
          wdata_nx = bus.d_wr_data;
        end else if (bus.d_miss) begin
          state_nx   = FILL_D;
          addr_nx    = bus.d_miss_addr & BASE_MASK;
          iss_act_nx = 1'b1;
        end else if (bus.i_miss) begin
          state_nx   = FILL_I;
          addr_nx    = bus.i_miss_addr & BASE_MASK;
          iss_act_nx = 1'b1;
        end
      end

      FILL_I, FILL_D: begin
        // Issue and return run independently; returns lag issues by the memory latency
        if (iss_act) begin
          en_c       = 1'b1;
          maddr_c    = addr_q + 16'({iss_cnt, 1'b0});
          iss_cnt_nx = iss_cnt + 1'b1;
          if (iss_cnt == LAST_IDX) iss_act_nx = 1'b0;
        end
        if (bus.mem_data_valid) begin
          iwe_c      = (state == FILL_I);
          dwe_c      = (state == FILL_D);
          idx_c      = ret_cnt;
          fdata_c    = bus.mem_rdata;
          ret_cnt_nx = ret_cnt + 1'b1;
          if (ret_cnt == LAST_IDX) begin
            idone_c  = (state == FILL_I);
            ddone_c  = (state == FILL_D);
            state_nx = IDLE;
          end
        end
      end

      WRITE: begin
        if (lat_cnt == '0) begin
          en_c     = 1'b1;
          wr_c     = 1'b1;
          maddr_c  = addr_q;
          mwdata_c = wdata_q;
        end
        if (lat_cnt == LAST_LAT) begin
          wdone_c    = 1'b1;
          state_nx   = IDLE;
          lat_cnt_nx = '0;
        end else begin
          lat_cnt_nx = lat_cnt + 1'b1;
        end
      end

      default: state_nx = DRAIN;
    endcase
  end

  // Reset forces every strobe low at once so an aborted fill cannot write
  assign bus.mem_en      = rst_n & en_c;
  assign bus.mem_wr      = rst_n & wr_c;
  assign bus.mem_addr    = rst_n ? maddr_c : '0;
  assign bus.mem_wdata   = rst_n ? mwdata_c : '0;
  assign bus.i_fill_we   = rst_n & iwe_c;
  assign bus.d_fill_we   = rst_n & dwe_c;
  assign bus.fill_idx    = rst_n ? idx_c : '0;
  assign bus.fill_data   = rst_n ? fdata_c : '0;
  assign bus.i_fill_done = rst_n & idone_c;
  assign bus.d_fill_done = rst_n & ddone_c;
  assign bus.d_wr_done   = rst_n & wdone_c;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter: per-cycle expected port image built from an
// operation schedule, with a fixed-latency memory model answering reads.
module tb_mem_fill_arbiter;
  localparam int unsigned L    = 4;
  localparam int unsigned BW   = 8;
  localparam int unsigned IW   = 3;
  localparam int          MAXC = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mem_fill_arbiter_if #(.BLOCK_WORDS(BW)) bus ();
  mem_fill_arbiter #(.MEM_LATENCY(L), .BLOCK_WORDS(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy, en, wr;
    logic [15:0] addr, wdata;
    logic iwe, dwe;
    logic [IW-1:0] idx;
    logic [15:0] data;
    logic idone, ddone, wdone;
  } snap_t;

  typedef struct packed {
    logic rst_n, i_miss;
    logic [15:0] i_addr;
    logic d_miss;
    logic [15:0] d_addr;
    logic wr_req;
    logic [15:0] wr_addr, wr_data;
    logic spur;
  } drv_t;

  typedef struct {
    logic [15:0] addr;
    int due;
  } pend_t;

  snap_t exp_s [MAXC];
  snap_t obs_s [MAXC];
  bit    care  [MAXC];
  drv_t  drv   [MAXC];
  pend_t pend[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    gcyc  = 0;
  logic [15:0] salt;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'(a * 16'd40503) ^ salt;
  endfunction

  function automatic void clear_plan(input int n);
    for (int c = 0; c < n; c++) begin
      exp_s[c] = '0;
      care[c] = 1'b1;
      drv[c] = '0;
      drv[c].rst_n = 1'b1;
    end
  endfunction

  // A fill occupies BW+L cycles: BW issues, then returns L cycles behind each issue
  function automatic int paint_fill(input int s, input bit is_d, input logic [15:0] base);
    for (int c = s; c < s + BW + L; c++) exp_s[c].busy = 1'b1;
    for (int k = 0; k < BW; k++) begin
      exp_s[s+k].en     = 1'b1;
      exp_s[s+k].addr   = 16'(base + 2 * k);
      exp_s[s+L+k].iwe  = !is_d;
      exp_s[s+L+k].dwe  = is_d;
      exp_s[s+L+k].idx  = IW'(k);
      exp_s[s+L+k].data = mem_word(16'(base + 2 * k));
    end
    exp_s[s+L+BW-1].idone = !is_d;
    exp_s[s+L+BW-1].ddone = is_d;
    return s + L + BW - 1;
  endfunction

  function automatic int paint_write(input int s, input logic [15:0] a, input logic [15:0] d);
    for (int c = s; c < s + L; c++) exp_s[c].busy = 1'b1;
    exp_s[s].en    = 1'b1;
    exp_s[s].wr    = 1'b1;
    exp_s[s].addr  = a;
    exp_s[s].wdata = d;
    exp_s[s+L-1].wdone = 1'b1;
    return s + L - 1;
  endfunction

  // Reset low for nlow cycles from rc, then L drain cycles; returns first idle cycle
  function automatic int paint_reset(input int rc, input int nlow, input int n);
    logic b;
    for (int c = rc; c < n; c++) begin
      b = exp_s[c].busy;
      exp_s[c] = '0;
      drv[c] = '0;
      drv[c].rst_n = 1'b1;
      if (c < rc + nlow) begin
        drv[c].rst_n = 1'b0;
        exp_s[c].busy = (c == rc) ? b : 1'b1;
      end else if (c < rc + nlow + L) begin
        exp_s[c].busy = 1'b1;
      end
    end
    return rc + nlow + L;
  endfunction

  // Requests raised at r, first sampled in idle cycle g; served write > dmiss > imiss,
  // one idle cycle between; request address scrambled once granted
  function automatic int plan_ops(input int r, input int g, input bit dw, input bit dd, input bit di,
                                  input logic [15:0] wa, input logic [15:0] wd,
                                  input logic [15:0] da, input logic [15:0] ia);
    int s, e, dn;
    bit on;
    s = g + 1;
    e = r;
    for (int op = 0; op < 3; op++) begin
      on = (op == 0) ? dw : (op == 1) ? dd : di;
      if (on) begin
        if (op == 0) dn = paint_write(s, wa, wd);
        else dn = paint_fill(s, op == 1,
                             16'((int'((op == 1) ? da : ia) / (2 * BW)) * (2 * BW)));
        for (int c = r; c <= dn; c++) begin
          if (op == 0) begin
            drv[c].wr_req  = 1'b1;
            drv[c].wr_addr = (c < s) ? wa : 16'($urandom);
            drv[c].wr_data = (c < s) ? wd : 16'($urandom);
          end else if (op == 1) begin
            drv[c].d_miss = 1'b1;
            drv[c].d_addr = (c < s) ? da : 16'($urandom);
          end else begin
            drv[c].i_miss = 1'b1;
            drv[c].i_addr = (c < s) ? ia : 16'($urandom);
          end
        end
        e = dn;
        s = dn + 2;
      end
    end
    return e;
  endfunction

  // Drives the planned inputs and memory returns, captures outputs mid-cycle
  task automatic run_window(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      gcyc++;
      rst_n           = drv[c].rst_n;
      bus.i_miss      = drv[c].i_miss;
      bus.i_miss_addr = drv[c].i_addr;
      bus.d_miss      = drv[c].d_miss;
      bus.d_miss_addr = drv[c].d_addr;
      bus.d_wr_req    = drv[c].wr_req;
      bus.d_wr_addr   = drv[c].wr_addr;
      bus.d_wr_data   = drv[c].wr_data;
      bus.mem_data_valid = 1'b0;
      bus.mem_rdata      = '0;
      while (pend.size() > 0 && pend[0].due < gcyc) void'(pend.pop_front());
      if (pend.size() > 0 && pend[0].due == gcyc) begin
        bus.mem_data_valid = 1'b1;
        bus.mem_rdata      = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else if (drv[c].spur) begin
        bus.mem_data_valid = 1'b1;
        bus.mem_rdata      = 16'($urandom);
      end
      @(negedge clk);
      obs_s[c].busy  = bus.busy;
      obs_s[c].en    = bus.mem_en;
      obs_s[c].wr    = bus.mem_wr;
      obs_s[c].addr  = bus.mem_addr;
      obs_s[c].wdata = bus.mem_wdata;
      obs_s[c].iwe   = bus.i_fill_we;
      obs_s[c].dwe   = bus.d_fill_we;
      obs_s[c].idx   = bus.fill_idx;
      obs_s[c].data  = bus.fill_data;
      obs_s[c].idone = bus.i_fill_done;
      obs_s[c].ddone = bus.d_fill_done;
      obs_s[c].wdone = bus.d_wr_done;
      if (bus.mem_en && !bus.mem_wr) pend.push_back('{addr: bus.mem_addr, due: gcyc + L});
    end
  endtask

  task automatic test_reset();
    int n = 12;
    snap_t o;
    clear_plan(n);
    void'(paint_reset(0, 3, n));
    care[0] = 1'b0;
    drv[5].spur = 1'b1;
    drv[9].spur = 1'b1;
    run_window(n);
    for (int c = 0; c < n; c++) if (care[c]) begin
      o = obs_s[c];
      if (!(exp_s[c].iwe || exp_s[c].dwe)) begin o.idx = '0; o.data = '0; end
      n_cmp++;
      if (o !== exp_s[c]) begin
        n_bad++;
        $display("FAIL reset cyc %0d: got %h want %h", c, o, exp_s[c]);
      end
    end
  endtask

  task automatic test_fill_i();
    int n, g, e;
    snap_t o;
    n = 20;
    clear_plan(n);
    g = paint_reset(0, 1, n);
    e = plan_ops(1, g, 1'b0, 1'b0, 1'b1, '0, '0, '0, 16'h1236);
    n = e + 3;
    run_window(n);
    for (int c = 0; c < n; c++) if (care[c]) begin
      o = obs_s[c];
      if (!(exp_s[c].iwe || exp_s[c].dwe)) begin o.idx = '0; o.data = '0; end
      n_cmp++;
      if (o !== exp_s[c]) begin
        n_bad++;
        $display("FAIL fill_i cyc %0d: got %h want %h", c, o, exp_s[c]);
      end
    end
  endtask

  task automatic test_write();
    int n, e;
    snap_t o;
    clear_plan(MAXC);
    e = plan_ops(0, 0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'hBEEF, '0, '0);
    n = e + 3;
    run_window(n);
    for (int c = 0; c < n; c++) if (care[c]) begin
      o = obs_s[c];
      if (!(exp_s[c].iwe || exp_s[c].dwe)) begin o.idx = '0; o.data = '0; end
      n_cmp++;
      if (o !== exp_s[c]) begin
        n_bad++;
        $display("FAIL write cyc %0d: got %h want %h", c, o, exp_s[c]);
      end
    end
  endtask

  task automatic test_priority();
    int n, e;
    snap_t o;
    clear_plan(MAXC);
    e = plan_ops(0, 0, 1'b1, 1'b1, 1'b1, 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom));
    n = e + 3;
    run_window(n);
    for (int c = 0; c < n; c++) if (care[c]) begin
      o = obs_s[c];
      if (!(exp_s[c].iwe || exp_s[c].dwe)) begin o.idx = '0; o.data = '0; end
      n_cmp++;
      if (o !== exp_s[c]) begin
        n_bad++;
        $display("FAIL priority cyc %0d: got %h want %h", c, o, exp_s[c]);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    int n, g, e;
    snap_t o;
    n = MAXC;
    clear_plan(n);
    void'(plan_ops(0, 0, 1'b0, 1'b0, 1'b1, '0, '0, '0, 16'($urandom)));
    g = paint_reset(1 + L + 3, 1, n);
    e = plan_ops(1 + L + 4, g, 1'b0, 1'b1, 1'b0, '0, '0, 16'h0100, '0);
    n = e + 3;
    run_window(n);
    for (int c = 0; c < n; c++) if (care[c]) begin
      o = obs_s[c];
      if (!(exp_s[c].iwe || exp_s[c].dwe)) begin o.idx = '0; o.data = '0; end
      n_cmp++;
      if (o !== exp_s[c]) begin
        n_bad++;
        $display("FAIL reset_mid_fill cyc %0d: got %h want %h", c, o, exp_s[c]);
      end
    end
  endtask

  task automatic test_drop_mid_fill();
    int n, e;
    snap_t o;
    clear_plan(MAXC);
    e = plan_ops(1, 1, 1'b0, 1'b0, 1'b1, '0, '0, '0, 16'($urandom));
    for (int c = 5; c <= e; c++) drv[c].i_miss = 1'b0;
    drv[0].spur = 1'b1;
    drv[1].spur = 1'b1;
    drv[e+1].spur = 1'b1;
    drv[e+2].spur = 1'b1;
    n = e + 4;
    run_window(n);
    for (int c = 0; c < n; c++) if (care[c]) begin
      o = obs_s[c];
      if (!(exp_s[c].iwe || exp_s[c].dwe)) begin o.idx = '0; o.data = '0; end
      n_cmp++;
      if (o !== exp_s[c]) begin
        n_bad++;
        $display("FAIL drop_mid_fill cyc %0d: got %h want %h", c, o, exp_s[c]);
      end
    end
  endtask

  task automatic test_random();
    int n, e, gap;
    int unsigned sel;
    snap_t o;
    for (int it = 0; it < 6; it++) begin
      clear_plan(MAXC);
      gap = int'($urandom_range(0, 2));
      sel = $urandom_range(1, 7);
      for (int c = 0; c < gap; c++) drv[c].spur = 1'($urandom);
      e = plan_ops(gap, gap, sel[0], sel[1], sel[2], 16'($urandom), 16'($urandom),
                   16'($urandom), 16'($urandom));
      n = e + 3;
      run_window(n);
      for (int c = 0; c < n; c++) if (care[c]) begin
        o = obs_s[c];
        if (!(exp_s[c].iwe || exp_s[c].dwe)) begin o.idx = '0; o.data = '0; end
        n_cmp++;
        if (o !== exp_s[c]) begin
          n_bad++;
          $display("FAIL random it %0d cyc %0d: got %h want %h", it, c, o, exp_s[c]);
        end
      end
    end
  endtask

  initial begin
    salt               = 16'($urandom);
    rst_n              = 1'b0;
    bus.i_miss         = 1'b0;
    bus.i_miss_addr    = '0;
    bus.d_miss         = 1'b0;
    bus.d_miss_addr    = '0;
    bus.d_wr_req       = 1'b0;
    bus.d_wr_addr      = '0;
    bus.d_wr_data      = '0;
    bus.mem_data_valid = 1'b0;
    bus.mem_rdata      = '0;
    test_reset();
    test_fill_i();
    test_write();
    test_priority();
    test_reset_mid_fill();
    test_drop_mid_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_fill_arbiter.md
MEM_FILL_ARBITER -- requirements
Module: mem_fill_arbiter

Interface
REQ-001 SHALL provide parameter MEM_LATENCY, default 4: cycles from a memory address issue to its read data returning.
REQ-002 SHALL provide parameter BLOCK_WORDS, default 8: 16-bit words per cache block, power of two.
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_miss  in  1  I-cache miss request; level, held until i_fill_done.
REQ-006 i_miss_addr  in  16  I-cache miss byte address.
REQ-007 d_miss  in  1  D-cache miss request; level, held until d_fill_done.
REQ-008 d_miss_addr  in  16  D-cache miss byte address.
REQ-009 d_wr_req  in  1  write-through store request; level, held until d_wr_done.
REQ-010 d_wr_addr / d_wr_data  in  16/16  store byte address and data.
REQ-011 mem_data_valid / mem_rdata  in  1/16  memory read return and data.
REQ-012 mem_en / mem_wr  out  1/1  memory access strobe and write select.
REQ-013 mem_addr / mem_wdata  out  16/16  memory byte address and write data.
REQ-014 i_fill_we / d_fill_we  out  1/1  write the returned word into the I-cache or D-cache data array.
REQ-015 fill_idx / fill_data  out  log2(BLOCK_WORDS)/16  word offset within the block, and the returned word.
REQ-016 i_fill_done / d_fill_done / d_wr_done  out  1 each  one-cycle completion pulses.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement states DRAIN, IDLE, FILL_I, FILL_D, WRITE.
REQ-019 In IDLE, grant priority SHALL be d_wr_req > d_miss > i_miss; the request is sampled at the edge and the new state entered on that edge.
REQ-020 At grant, the requested address SHALL be latched; later changes to request inputs SHALL be ignored until done.
REQ-021 Fill base address SHALL be {addr[15:log2(2*BLOCK_WORDS)], zeros}; word k SHALL be at base+2k.
REQ-022 FILL: mem_en=1 and mem_wr=0 SHALL hold for the first BLOCK_WORDS cycles; mem_addr SHALL be base+2k in the k-th cycle (k=0..BLOCK_WORDS-1).
REQ-023 The issue counter and return counter SHALL be independent; issue wraps at BLOCK_WORDS, and issue stops after the last word.
REQ-024 Each mem_data_valid in FILL SHALL assert i_fill_we or d_fill_we (per state) in the same cycle; fill_data=mem_rdata; fill_idx=return count (0..BLOCK_WORDS-1).
REQ-025 The done pulse SHALL coincide with the last fill_we; the next state SHALL be IDLE; FILL SHALL last BLOCK_WORDS+MEM_LATENCY cycles (default 12).
REQ-026 WRITE: the first cycle SHALL drive mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data; WRITE SHALL then hold for MEM_LATENCY cycles total; d_wr_done SHALL pulse in the last cycle; the next state SHALL be IDLE.
REQ-027 mem_data_valid outside FILL, or beyond BLOCK_WORDS returns, SHALL be ignored: no fill_we, no counter change.
REQ-028 A request deasserted mid-operation SHALL NOT abort it; the operation completes and pulses done.
REQ-029 Back-to-back operations: a request pending at the done edge SHALL be granted at the earliest on the following edge; IDLE lasts at least one cycle.
REQ-030 Outside active issue cycles: mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.

Reset
REQ-031 While rst_n=0 at an edge: state SHALL go to DRAIN; all counters SHALL clear; all outputs SHALL be 0, except busy=1 in DRAIN.
REQ-032 DRAIN SHALL last MEM_LATENCY cycles after rst_n rises, granting nothing and ignoring mem_data_valid, so stale returns are flushed; it then goes to IDLE.
REQ-033 Reset asserted mid-FILL or mid-WRITE SHALL abort immediately; no done pulse; no fill_we afterward.

Verification
REQ-034 Reset, then i_miss=1 with i_miss_addr=0x1236 -> after 4 DRAIN cycles: mem_addr 0x1230..0x123E on 8 consecutive cycles; 8 i_fill_we with fill_idx 0..7; i_fill_done on return 8, 12 cycles after grant.
REQ-035 d_wr_req, d_miss and i_miss rise together -> order WRITE, then FILL_D, then FILL_I; each separated by exactly one IDLE cycle.
REQ-036 d_wr_req with addr 0x0040 and data 0xBEEF -> one cycle mem_en=1, mem_wr=1, 0x0040/0xBEEF; d_wr_done 4 cycles after grant.
REQ-037 rst_n low at fill return 3, memory model still returning words 4..7 -> no fill_we; DRAIN absorbs them; a subsequent d_miss to 0x0100 fills cleanly, idx 0..7.
REQ-038 Spurious mem_data_valid in IDLE, and i_miss dropped mid-fill -> no fill_we in IDLE; the fill still completes with 8 writes and i_fill_done.
